layer_sched_ctrl: RTL and testbench

// - Frame-level scheduler for the CNN pipeline: issues the conv start pulse to Conv1_1/Conv2 and the pool start pulse to Relu3.
// - Owns a two-bank ping-pong ownership scheme for the layer-2 result RAM, so conv of frame N+1 overlaps pooling of frame N.
// - Per-stage watchdogs; sits between the host frame request and GarbageSortTop's layer control signals.

---
 rtl/layer_sched_ctrl_pkg.sv | 19 +
 rtl/layer_sched_ctrl_if.sv | 53 +++++
 rtl/layer_sched_ctrl_stage_watchdog.sv | 40 ++++
 rtl/layer_sched_ctrl.sv | 160 ++++++++++++++++
 tb/tb_layer_sched_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_sched_ctrl_pkg.sv
// layer_sched_pkg: shared types for the frame scheduler.
// Producer/consumer state enums, default watchdog limit, bank index.
package layer_sched_pkg;

  localparam int unsigned TIMEOUT_DEF = 1000000;

  typedef enum logic {
    P_IDLE,
    P_RUN
  } p_state_e;

  typedef enum logic {
    C_IDLE,
    C_RUN
  } c_state_e;

  typedef logic bank_t;

endpackage

// File: rtl/layer_sched_ctrl_if.sv
// layer_sched_ctrl_if: host/layer control bundle of the scheduler.
// master = host + conv/pool layers side, slave = scheduler side.
interface layer_sched_ctrl_if #(
  parameter int FRAME_CNT_W = 16
);

  logic                   frame_req;
  logic                   frame_ack;
  logic                   conv_start;
  logic                   conv_2_write_complete;
  logic                   layer_3_relu_begin;
  logic                   relu_3_complete;
  logic                   wr_bank;
  logic                   rd_bank;
  logic                   busy;
  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   timeout_err;
  logic                   err_clr;

  modport master (
    output frame_req,
    output conv_2_write_complete,
    output relu_3_complete,
    output err_clr,
    input  frame_ack,
    input  conv_start,
    input  layer_3_relu_begin,
    input  wr_bank,
    input  rd_bank,
    input  busy,
    input  frame_done,
    input  frame_cnt,
    input  timeout_err
  );

  modport slave (
    input  frame_req,
    input  conv_2_write_complete,
    input  relu_3_complete,
    input  err_clr,
    output frame_ack,
    output conv_start,
    output layer_3_relu_begin,
    output wr_bank,
    output rd_bank,
    output busy,
    output frame_done,
    output frame_cnt,
    output timeout_err
  );

endinterface

// File: rtl/layer_sched_ctrl_stage_watchdog.sv
// stage_watchdog: counts cycles while run=1, clr zeroes the count.
// Ports: clk, rst (async low), clr, run, expire (comb, in cycle N of run).
module stage_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int          TO_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count holds n-1 during the n-th run cycle.
  assign expire = run && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/layer_sched_ctrl.sv
// layer_sched_ctrl: frame scheduler with ping-pong layer-2 RAM banks.
// Ports: clk, rst (async low), bus (slave side of layer_sched_ctrl_if).
module layer_sched_ctrl
  import layer_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int          TO_W           = 20,
  parameter int          FRAME_CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  layer_sched_ctrl_if.slave  bus
);

  p_state_e               p_q, p_d;
  c_state_e               c_q, c_d;
  logic [1:0]             full_q, full_d;
  bank_t                  wr_q, wr_d;
  bank_t                  rd_q, rd_d;
  logic                   ack_q, ack_d;
  logic                   beg_q, beg_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  logic p_acc, c_acc;
  logic p_to, c_to;
  logic p_exp, c_exp;

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_p_wd (
    .clk   (clk),
    .rst   (rst),
    .clr   (p_acc),
    .run   (p_q == P_RUN),
    .expire(p_exp)
  );

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_c_wd (
    .clk   (clk),
    .rst   (rst),
    .clr   (c_acc),
    .run   (c_q == C_RUN),
    .expire(c_exp)
  );

  always_comb begin
    p_d    = p_q;
    c_d    = c_q;
    full_d = full_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ack_d  = 1'b0;
    beg_d  = 1'b0;
    done_d = 1'b0;
    p_acc  = 1'b0;
    c_acc  = 1'b0;
    p_to   = 1'b0;
    c_to   = 1'b0;

    unique case (p_q)
      P_IDLE: begin
        if (bus.frame_req && !full_q[wr_q]) begin
          p_acc = 1'b1;
          ack_d = 1'b1;
          p_d   = P_RUN;
        end
      end
      P_RUN: begin
        // Completion beats a same-cycle expiry.
        if (bus.conv_2_write_complete) begin
          full_d[wr_q] = 1'b1;
          wr_d         = ~wr_q;
          p_d          = P_IDLE;
        end else if (p_exp) begin
          p_to = 1'b1;
          p_d  = P_IDLE;
        end
      end
      default: p_d = P_IDLE;
    endcase

    // Producer only sets an empty bank, consumer only clears a
    // full one, so the two bank_full writes never collide.
    unique case (c_q)
      C_IDLE: begin
        if (full_q[rd_q]) begin
          c_acc = 1'b1;
          beg_d = 1'b1;
          c_d   = C_RUN;
        end
      end
      C_RUN: begin
        if (bus.relu_3_complete) begin
          full_d[rd_q] = 1'b0;
          rd_d         = ~rd_q;
          done_d       = 1'b1;
          cnt_d        = cnt_q + 1'b1;
          c_d          = C_IDLE;
        end else if (c_exp) begin
          full_d[rd_q] = 1'b0;
          rd_d         = ~rd_q;
          c_to         = 1'b1;
          c_d          = C_IDLE;
        end
      end
      default: c_d = C_IDLE;
    endcase

    err_d = err_q;
    if (p_to || c_to) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q    <= P_IDLE;
      c_q    <= C_IDLE;
      full_q <= 2'b00;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      ack_q  <= 1'b0;
      beg_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      p_q    <= p_d;
      c_q    <= c_d;
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ack_q  <= ack_d;
      beg_q  <= beg_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.frame_ack          = ack_q;
  assign bus.conv_start         = ack_q;
  assign bus.layer_3_relu_begin = beg_q;
  assign bus.frame_done         = done_q;
  assign bus.wr_bank            = wr_q;
  assign bus.rd_bank            = rd_q;
  assign bus.frame_cnt          = cnt_q;
  assign bus.timeout_err        = err_q;
  assign bus.busy = (p_q == P_RUN) || (c_q == C_RUN) || (|full_q);

endmodule

// File: tb/tb_layer_sched_ctrl.sv
// tb_layer_sched_ctrl: self-checking bench for layer_sched_ctrl.
// Frame table, overlap, watchdog and async-reset sequences.
module tb_layer_sched_ctrl;

  localparam int TO = 16;
  localparam int CW = 16;

  typedef struct {
    int conv_n;
    int pool_n;
    bit exp_bank;
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer_sched_ctrl_if #(.FRAME_CNT_W(CW)) bus ();

  layer_sched_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .TO_W          (8),
    .FRAME_CNT_W   (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int sb_q[$];
  int n_ack = 0;
  int n_beg = 0;
  int n_done = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_ack === 1'b1) n_ack++;
      if (bus.layer_3_relu_begin === 1'b1) n_beg++;
      if (bus.frame_done === 1'b1) begin
        n_done++;
        chk("sb_nonempty_at_done", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0)
          chk("frame_cnt_at_done", 32'(bus.frame_cnt),
              sb_q.pop_front());
      end
    end
  end

  task automatic run_frame(input int idx, input frame_vec_t v);
    bus.frame_req = 1'b1;
    step();
    bus.frame_req = 1'b0;
    chk($sformatf("ack_f%0d", idx), 32'(bus.frame_ack), 1);
    chk($sformatf("conv_start_f%0d", idx), 32'(bus.conv_start), 1);
    chk($sformatf("busy_run_f%0d", idx), 32'(bus.busy), 1);
    repeat (v.conv_n - 1) step();
    bus.conv_2_write_complete = 1'b1;
    step();
    bus.conv_2_write_complete = 1'b0;
    chk($sformatf("wr_bank_f%0d", idx), 32'(bus.wr_bank),
        32'(v.exp_bank));
    chk($sformatf("beg_early_f%0d", idx),
        32'(bus.layer_3_relu_begin), 0);
    step();
    chk($sformatf("relu_begin_f%0d", idx),
        32'(bus.layer_3_relu_begin), 1);
    repeat (v.pool_n - 1) step();
    bus.relu_3_complete = 1'b1;
    exp_cnt++;
    sb_q.push_back(exp_cnt);
    step();
    bus.relu_3_complete = 1'b0;
    chk($sformatf("frame_done_f%0d", idx), 32'(bus.frame_done), 1);
    chk($sformatf("rd_bank_f%0d", idx), 32'(bus.rd_bank),
        32'(v.exp_bank));
    chk($sformatf("no_err_f%0d", idx), 32'(bus.timeout_err), 0);
    step();
    chk($sformatf("busy_idle_f%0d", idx), 32'(bus.busy), 0);
  endtask

  initial begin
    frame_vec_t vt[4];
    int ack_t[$];
    int cs_t[$];
    int beg_t[$];
    int done_t[$];
    int exp_ack[3];
    int exp_beg[3];
    int exp_done[3];
    int conv_due;
    int pool_due;
    int a0, b0, d0;

    vt[0] = '{conv_n: 5,  pool_n: 3,  exp_bank: 1'b1};
    vt[1] = '{conv_n: 1,  pool_n: 1,  exp_bank: 1'b0};
    vt[2] = '{conv_n: 16, pool_n: 16, exp_bank: 1'b1};
    vt[3] = '{conv_n: 9,  pool_n: 2,  exp_bank: 1'b0};
    exp_ack  = '{1, 4, 15};
    exp_beg  = '{4, 15, 26};
    exp_done = '{14, 25, 36};

    bus.frame_req = 1'b0;
    bus.conv_2_write_complete = 1'b0;
    bus.relu_3_complete = 1'b0;
    bus.err_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_bank", 32'(bus.wr_bank), 0);
    chk("rst_rd_bank", 32'(bus.rd_bank), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    chk("rst_frame_ack", 32'(bus.frame_ack), 0);
    rst = 1'b1;
    step();

    bus.conv_2_write_complete = 1'b1;
    bus.relu_3_complete = 1'b1;
    step();
    bus.conv_2_write_complete = 1'b0;
    bus.relu_3_complete = 1'b0;
    step();
    chk("spur_wr_bank", 32'(bus.wr_bank), 0);
    chk("spur_rd_bank", 32'(bus.rd_bank), 0);
    chk("spur_busy", 32'(bus.busy), 0);
    chk("spur_frame_cnt", 32'(bus.frame_cnt), 0);
    chk("spur_pulses", 32'(n_ack + n_beg + n_done), 0);

    foreach (vt[i]) run_frame(i, vt[i]);
    chk("table_frame_cnt", 32'(bus.frame_cnt), 4);

    conv_due = -1;
    pool_due = -1;
    bus.frame_req = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      step();
      bus.conv_2_write_complete = 1'b0;
      bus.relu_3_complete = 1'b0;
      if (bus.frame_ack) begin
        ack_t.push_back(t);
        conv_due = t + 1;
        if (ack_t.size() == 3) bus.frame_req = 1'b0;
      end
      if (bus.conv_start) cs_t.push_back(t);
      if (bus.layer_3_relu_begin) begin
        beg_t.push_back(t);
        pool_due = t + 9;
      end
      if (bus.frame_done) done_t.push_back(t);
      if (t == conv_due) bus.conv_2_write_complete = 1'b1;
      if (t == pool_due) begin
        bus.relu_3_complete = 1'b1;
        exp_cnt++;
        sb_q.push_back(exp_cnt);
      end
    end
    chk("ovl_ack_count", 32'(ack_t.size()), 3);
    chk("ovl_beg_count", 32'(beg_t.size()), 3);
    chk("ovl_done_count", 32'(done_t.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovl_ack_cyc%0d", i),
          ack_t.size() > i ? ack_t[i] : -1, exp_ack[i]);
      chk($sformatf("ovl_cs_cyc%0d", i),
          cs_t.size() > i ? cs_t[i] : -1, exp_ack[i]);
      chk($sformatf("ovl_beg_cyc%0d", i),
          beg_t.size() > i ? beg_t[i] : -1, exp_beg[i]);
      chk($sformatf("ovl_done_cyc%0d", i),
          done_t.size() > i ? done_t[i] : -1, exp_done[i]);
    end
    chk("ovl_frame_cnt", 32'(bus.frame_cnt), 7);
    chk("ovl_busy", 32'(bus.busy), 0);
    chk("ovl_wr_bank", 32'(bus.wr_bank), 1);
    chk("ovl_rd_bank", 32'(bus.rd_bank), 1);

    bus.frame_req = 1'b1;
    step();
    bus.frame_req = 1'b0;
    chk("wdp_ack", 32'(bus.frame_ack), 1);
    repeat (15) step();
    chk("wdp_err_pre", 32'(bus.timeout_err), 0);
    step();
    chk("wdp_err", 32'(bus.timeout_err), 1);
    chk("wdp_wr_same", 32'(bus.wr_bank), 1);
    chk("wdp_busy", 32'(bus.busy), 0);
    chk("wdp_no_begin", 32'(bus.layer_3_relu_begin), 0);
    bus.frame_req = 1'b1;
    bus.err_clr = 1'b1;
    step();
    bus.frame_req = 1'b0;
    bus.err_clr = 1'b0;
    chk("wdp_reack", 32'(bus.frame_ack), 1);
    chk("wdp_err_clr", 32'(bus.timeout_err), 0);
    chk("wdp_reack_wr", 32'(bus.wr_bank), 1);
    repeat (15) step();
    bus.conv_2_write_complete = 1'b1;
    step();
    bus.conv_2_write_complete = 1'b0;
    chk("wdp_edge_no_err", 32'(bus.timeout_err), 0);
    chk("wdp_edge_wr", 32'(bus.wr_bank), 0);
    step();
    chk("wdc_begin", 32'(bus.layer_3_relu_begin), 1);
    repeat (15) step();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("wdc_err_prio", 32'(bus.timeout_err), 1);
    chk("wdc_rd_toggle", 32'(bus.rd_bank), 0);
    chk("wdc_frame_cnt", 32'(bus.frame_cnt), 7);
    chk("wdc_no_done", 32'(bus.frame_done), 0);
    chk("wdc_busy", 32'(bus.busy), 0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("wdc_err_clr", 32'(bus.timeout_err), 0);
    chk("total_done", 32'(n_done), 7);

    bus.frame_req = 1'b1;
    step();
    bus.conv_2_write_complete = 1'b1;
    step();
    bus.conv_2_write_complete = 1'b0;
    step();
    chk("mid_ack2", 32'(bus.frame_ack), 1);
    chk("mid_begin", 32'(bus.layer_3_relu_begin), 1);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wr_bank", 32'(bus.wr_bank), 0);
    chk("arst_rd_bank", 32'(bus.rd_bank), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_frame_cnt", 32'(bus.frame_cnt), 0);
    chk("arst_pulses", 32'({bus.frame_ack, bus.conv_start,
        bus.layer_3_relu_begin, bus.frame_done}), 0);
    sb_q.delete();
    exp_cnt = 0;
    bus.frame_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    a0 = n_ack;
    b0 = n_beg;
    d0 = n_done;
    repeat (20) step();
    chk("post_rst_ack", 32'(n_ack - a0), 0);
    chk("post_rst_beg", 32'(n_beg - b0), 0);
    chk("post_rst_done", 32'(n_done - d0), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_cnt", 32'(bus.frame_cnt), 0);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
